// File: rtl/mips_run_ctrl_pkg.sv
// Shared state encoding and helpers for the MIPS run/pause/step sequencer.
package mips_run_ctrl_pkg;

  typedef enum logic [2:0] {
    RC_IDLE  = 3'd0,
    RC_RUN   = 3'd1,
    RC_PAUSE = 3'd2,
    RC_STEP  = 3'd3,
    RC_BRK   = 3'd4
  } rc_state_e;

  function automatic logic rc_enabled(rc_state_e s);
    return (s == RC_RUN) || (s == RC_STEP);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
module mips_run_ctrl_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_e
);

  logic btn_q;
  logic btn_d;

  always_comb btn_d = btn;

  always_ff @(posedge clk) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn_d;
  end

  assign btn_e = btn & ~btn_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/pause/single-step sequencer driving the core-wide enable, with cycle counter.
// Define MIPS_RUNCTRL_BREAKPOINT_EN to build the PC breakpoint, bp_skip and BRK state.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_btn,
  input  logic             step_btn,
  input  logic [PC_W-1:0]  d_pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic [2:0]       run_state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cyc_count
);

  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  rc_state_e        state_q, state_d;
  logic [CNT_W-1:0] step_ctr_q, step_ctr_d;
  logic [CNT_W-1:0] cyc_count_q, cyc_count_d;
  logic             play_e, step_e;
  logic             en;
  logic             bp_match;

  mips_run_ctrl_btn_edge u_play_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (play_btn),
    .btn_e (play_e)
  );

  mips_run_ctrl_btn_edge u_step_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (step_btn),
    .btn_e (step_e)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RC_IDLE;
      step_ctr_q  <= '0;
      cyc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      step_ctr_q  <= step_ctr_d;
      cyc_count_q <= cyc_count_d;
    end
  end

  // Breakpoint beats play and step expiry; play beats step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RC_IDLE, RC_PAUSE, RC_BRK: begin
        if (play_e)      state_d = RC_RUN;
        else if (step_e) state_d = RC_STEP;
      end
      RC_RUN: begin
        if (bp_match)    state_d = RC_BRK;
        else if (play_e) state_d = RC_PAUSE;
      end
      RC_STEP: begin
        if (bp_match)                state_d = RC_BRK;
        else if (play_e)             state_d = RC_RUN;
        else if (step_ctr_q == '0)   state_d = RC_PAUSE;
      end
      default: state_d = RC_IDLE;
    endcase
  end

  always_comb begin
    en        = rc_enabled(state_q);
    cpu_en    = en;
    run_state = state_q;
  end

  always_comb begin
    step_ctr_d = step_ctr_q;
    if (state_d == RC_STEP && state_q != RC_STEP)
      step_ctr_d = STEP_LOAD;
    else if (state_q == RC_STEP && step_ctr_q != '0)
      step_ctr_d = step_ctr_q - CNT_ONE;
  end

  always_comb begin
    cyc_count_d = cyc_count_q;
    if (en && cyc_count_q != CNT_MAX)
      cyc_count_d = cyc_count_q + CNT_ONE;
  end

  assign cyc_count = cyc_count_q;

`ifdef MIPS_RUNCTRL_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;
  logic bp_hit_q, bp_hit_d;

  assign bp_match = bp_valid & en & (d_pc == bp_addr) & ~bp_skip_q;

  // Skip lets a resume execute the trapped instruction instead of re-trapping on it.
  always_comb begin
    bp_skip_d = bp_skip_q;
    if (state_q == RC_BRK && state_d != RC_BRK) bp_skip_d = 1'b1;
    else if (en)                                bp_skip_d = 1'b0;
    bp_hit_d = bp_match;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_skip_q <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
      bp_hit_q  <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{d_pc, bp_addr, bp_valid};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Randomised self-checking bench for mips_run_ctrl against a behavioural model.
module tb_mips_run_ctrl;

  localparam int STEP_CYCLES = 3;
`ifdef MIPS_RUNCTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_STEP = 3, S_BRK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        play_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic [31:0] d_pc = '0;
  logic [31:0] bp_addr = '0;
  logic        bp_valid = 1'b0;

  logic        cpu_en, bp_hit;
  logic [2:0]  run_state;
  logic [31:0] cyc_count;
  logic        cpu_en4, bp_hit4;
  logic [2:0]  run_state4;
  logic [3:0]  cyc_count4;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model
  int          m_state = S_IDLE;
  int          m_left  = 0;
  bit          m_skip  = 0;
  bit          m_hit   = 0;
  bit          m_play_q = 0;
  bit          m_step_q = 0;
  longint      m_cnt   = 0;
  longint      m_cnt4  = 0;
  int          pc      = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .play_btn(play_btn), .step_btn(step_btn),
    .d_pc(d_pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_en(cpu_en), .run_state(run_state), .bp_hit(bp_hit), .cyc_count(cyc_count)
  );

  mips_run_ctrl #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(4), .PC_W(32)) dut_sat (
    .clk(clk), .rst_n(rst_n), .play_btn(play_btn), .step_btn(step_btn),
    .d_pc(d_pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_en(cpu_en4), .run_state(run_state4), .bp_hit(bp_hit4), .cyc_count(cyc_count4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare both DUTs.
  task automatic cycle();
    bit en, pe, se, match;
    int nxt, pc_n;
    en    = (m_state == S_RUN) || (m_state == S_STEP);
    pe    = play_btn && !m_play_q;
    se    = step_btn && !m_step_q;
    match = BP_EN && bp_valid && en && (d_pc == bp_addr) && !m_skip;
    if (!rst_n) begin
      m_state = S_IDLE; m_left = 0; m_skip = 0; m_hit = 0;
      m_cnt = 0; m_cnt4 = 0; m_play_q = 0; m_step_q = 0;
      pc_n = 0;
    end else begin
      nxt = m_state;
      if (match)                                        nxt = S_BRK;
      else if (pe)                                      nxt = (m_state == S_RUN) ? S_PAUSE : S_RUN;
      else if (se && m_state != S_RUN && m_state != S_STEP) nxt = S_STEP;
      else if (m_state == S_STEP && m_left == 1)        nxt = S_PAUSE;
      if (nxt == S_STEP && m_state != S_STEP) m_left = STEP_CYCLES;
      else if (m_state == S_STEP)             m_left--;
      if (m_state == S_BRK && nxt != S_BRK) m_skip = 1;
      else if (en)                           m_skip = 0;
      m_hit = match;
      if (en) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15)           m_cnt4++;
      end
      m_play_q = play_btn;
      m_step_q = step_btn;
      m_state  = nxt;
      pc_n = (en && !match) ? (pc + 4) % 32 : pc;
    end
    @(posedge clk);
    #1;
    pc   = pc_n;
    d_pc = 32'(pc);
    chk("run_state", 64'(run_state), 64'(m_state));
    chk("cpu_en", 64'(cpu_en), 64'((m_state == S_RUN) || (m_state == S_STEP)));
    chk("bp_hit", 64'(bp_hit), 64'(m_hit));
    chk("cyc_count", 64'(cyc_count), 64'(m_cnt));
    chk("cyc_count_sat", 64'(cyc_count4), 64'(m_cnt4));
    chk("run_state_sat", 64'(run_state4), 64'(m_state));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_play();
    play_btn = 1'b1; cycle(); play_btn = 1'b0; cycle();
  endtask

  task automatic press_step();
    step_btn = 1'b1; cycle(); step_btn = 1'b0; cycle();
  endtask

  initial begin
    run(3);
    rst_n = 1'b1;
    run(2);
    // Play from idle, then pause and take a step burst
    press_play(); run(6);
    press_play(); run(2);
    press_step(); run(6);
    // Breakpoint trap, resume past it, then trap again on the next loop
    bp_addr = 32'h10; bp_valid = 1'b1;
    press_play(); run(10);
    press_play(); run(14);
    bp_valid = 1'b0;
    press_play(); run(2);
    press_play(); run(2);
    // Play and step rising together, then step while running
    play_btn = 1'b1; step_btn = 1'b1; cycle();
    play_btn = 1'b0; step_btn = 1'b0; run(3);
    press_step(); run(2);
    press_play(); run(2);
    // Reset in the middle of a step burst
    step_btn = 1'b1; cycle(); step_btn = 1'b0; cycle();
    rst_n = 1'b0; cycle(); rst_n = 1'b1; run(2);
    // Long run saturates the narrow counter
    press_play(); run(20);
    // Random phase
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0)  play_btn = ~play_btn;
      if ($urandom_range(7) == 0)  step_btn = ~step_btn;
      if ($urandom_range(31) == 0) bp_valid = ~bp_valid;
      if ($urandom_range(63) == 0) bp_addr  = ($urandom_range(1) == 1) ? 32'h10 : 32'h8;
      rst_n = ($urandom_range(199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    run(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
